clk_monitor: RTL and testbench
==============================

# clk_monitor

Receive-side checker for the slow clock produced by the team's clock divider. It samples an asynchronous slow clock in the `clk_in` domain and measures each half-period in `clk_in` cycles. It declares lock after a run of in-tolerance half-periods, and raises a sticky fault if the slow clock drifts or stops. It sits beside any block clocked or gated by the divided clock, so firmware and testbenches can confirm the divider is alive and at the expected ratio.

## Interface
Parameters:
- `EXPECTED_HALF`, 50: nominal half-period in `clk_in` cycles; matches the divider's default ratio.
- `TOLERANCE`, 2: allowed ± deviation in cycles; a half-period is good when it lies in [`EXPECTED_HALF`−`TOLERANCE`, `EXPECTED_HALF`+`TOLERANCE`].
- `LOCK_COUNT`, 4: number of consecutive good half-periods required for lock.
- `CNT_WIDTH`, 16: measurement counter width; must hold `EXPECTED_HALF`+`TOLERANCE`+1.

Ports:
- `clk_in`  input  1: the only clock.
- `reset_n`  input  1: asynchronous active-low reset.
- `enable`  input  1: monitor enable; low forces IDLE.
- `clock_slow_input`  input  1: monitored slow clock, asynchronous to `clk_in`.
- `clear_fault`  input  1: synchronous; leaves FAULT.
- `half_period`  output  CNT_WIDTH: last measured half-period.
- `measure_valid`  output  1: one-cycle pulse when `half_period` updates.
- `locked`  output  1: high while the state is LOCKED.
- `fault`  output  1: high while the state is FAULT.

## Operation
- **Input path**
  - A two-flop synchronizer feeds a third delay flop.
  - `edge_pulse` = sync2 XOR sync3, registered. Each transition of the slow clock yields exactly one one-cycle pulse.
  - The synchronizer runs regardless of `enable`.
- **Counter `half_cnt`**
  - Cleared to 0 on `edge_pulse`.
  - Increments on every other cycle and saturates at all-ones.
  - On `edge_pulse`, measured = `half_cnt`+1. Edge pulses N cycles apart therefore give measured = N.
- **State machine** (registered state, encoding in the shared header): IDLE, ACQUIRE, MEASURE, LOCKED, FAULT.
  - **IDLE:** `enable`=1 → ACQUIRE.
  - **ACQUIRE:** the first `edge_pulse` only restarts `half_cnt`; no capture → MEASURE. There is no timeout in this state.
  - **MEASURE:** each edge captures `half_period` and pulses `measure_valid`.
    - A good measurement increments `good_cnt`; a bad one clears it.
    - When `good_cnt` reaches `LOCK_COUNT` → LOCKED.
    - Timeout (no edge while `half_cnt` == `EXPECTED_HALF`+`TOLERANCE`) clears `good_cnt` → ACQUIRE.
  - **LOCKED:** edges still capture and pulse `measure_valid`. A bad measurement or a timeout → FAULT.
  - **FAULT:** no captures and no `measure_valid`. `clear_fault`=1 → ACQUIRE.
- **Priority:** reset > `enable`=0 (→ IDLE from any state, `good_cnt` cleared, `fault` dropped) > `clear_fault` > edge/timeout.
  - `clear_fault` arriving with an edge in FAULT: go to ACQUIRE; that edge is discarded.
  - `clear_fault` in any state other than FAULT is ignored.
- **Reset values:** `half_period`=0, `measure_valid`=0, `locked`=0, `fault`=0, state=IDLE, `good_cnt`=0, `half_cnt`=0, synchronizer flops=0.
  - Reset mid-operation returns every output to these values immediately (asynchronous), regardless of state.

## Timing
- A slow-clock transition sampled at `clk_in` edge k produces `edge_pulse` high in the cycle after edge k+2: 3-cycle latency.
- `half_period` and `measure_valid` are registered and update at the clock edge ending the `edge_pulse` cycle.
- `locked`/`fault` rise one cycle after the deciding edge pulse or timeout, in the same cycle `measure_valid` (if any) is seen.
- Lock latency with a clean input: `LOCK_COUNT`+1 slow-clock transitions after entering ACQUIRE.
- Timeout fires when `EXPECTED_HALF`+`TOLERANCE` cycles have elapsed since the last edge pulse without a new one.

## Structure
- **Shared header `clk_defs.vh`:** state encodings (3-bit), default `EXPECTED_HALF`/`TOLERANCE` constants shared with the divider instantiation.
- **Sub-module `sync_edge_detect`:** 2-flop synchronizer, delay flop, and registered edge pulse, with `clk_in`/`reset_n`. All counting and FSM logic stays in `clk_monitor`.

## Test plan
1. Toggle input every 50 `clk_in` cycles with `enable`=1 → first `measure_valid` with `half_period`=50 at the 2nd transition; `locked`=1 one cycle after the 5th transition's pulse; `fault`=0.
2. Toggle every 53 cycles → `measure_valid` with 53 at each transition; `locked` never rises; toggle every 48 → locks (in tolerance).
3. Locked at 50, then hold the input constant → `fault`=1 and `locked`=0, 52 cycles after the last edge pulse plus one register cycle; no `measure_valid`.
4. In FAULT, resume toggling at 50 and pulse `clear_fault` coincident with an edge pulse → ACQUIRE; relock after 5 further transitions.
5. Drop `enable` while locked → `locked`=0 next cycle; no `measure_valid` while low; re-enable → the full acquire sequence repeats.
6. Assert `reset_n`=0 mid-MEASURE with `half_period`=50 → all outputs 0 immediately; after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/clk_monitor_pkg.sv
// ----------------------------------------------------------------------------
// clk_monitor_pkg
// Shared definitions for the slow-clock monitor: default divider ratio and
// tolerance (kept identical to the divider instantiation), monitor state
// encodings and a small window-compare helper.
// ----------------------------------------------------------------------------
package clk_monitor_pkg;

    // Defaults shared with the clock divider instantiation
    localparam int unsigned DEF_EXPECTED_HALF = 50;
    localparam int unsigned DEF_TOLERANCE     = 2;
    localparam int unsigned DEF_LOCK_COUNT    = 4;
    localparam int unsigned DEF_CNT_WIDTH     = 16;

    localparam int unsigned STATE_W = 3;

    // Monitor state encoding
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } mon_state_t;

    // True when val lies in the closed interval [lo, hi]
    function automatic logic in_window(
        input logic [31:0] val,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (val >= lo) && (val <= hi);
    endfunction

endpackage : clk_monitor_pkg

// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk_in domain through a two-flop
// synchronizer, delays it one more cycle, and emits a registered one-cycle
// pulse for every transition (rising or falling) of the input.
//
// Ports:
//   clk_in        in   sampling clock
//   reset_n       in   asynchronous active-low reset
//   i_async       in   asynchronous level to observe
//   o_edge_pulse  out  one-cycle pulse per input transition (3-cycle latency)
// ----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk_in,
    input  logic reset_n,
    input  logic i_async,
    output logic o_edge_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_edge_pulse;

    // Two-flop synchronizer plus one delay flop for edge comparison
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Registered pulse: sync2 differs from its delayed copy for one cycle only
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_pulse <= 1'b0;
        end else begin
            r_edge_pulse <= r_sync2 ^ r_sync3;
        end
    end

    assign o_edge_pulse = r_edge_pulse;

endmodule : sync_edge_detect

// File: rtl/clk_monitor.sv
// ----------------------------------------------------------------------------
// clk_monitor
// Receive-side checker for the divided slow clock. Measures each half-period
// of clock_slow_input in clk_in cycles, declares lock after LOCK_COUNT
// consecutive in-tolerance half-periods, and raises a sticky fault when the
// locked clock drifts out of tolerance or stops toggling.
//
// Ports:
//   clk_in            in   the only clock
//   reset_n           in   asynchronous active-low reset
//   enable            in   monitor enable; low forces IDLE
//   clock_slow_input  in   monitored slow clock (asynchronous)
//   clear_fault       in   leaves FAULT (ignored in other states)
//   half_period       out  last measured half-period, clk_in cycles
//   measure_valid     out  one-cycle pulse when half_period updates
//   locked            out  high while LOCKED
//   fault             out  high while FAULT
// ----------------------------------------------------------------------------
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int unsigned EXPECTED_HALF = DEF_EXPECTED_HALF,
    parameter int unsigned TOLERANCE     = DEF_TOLERANCE,
    parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clock_slow_input,
    input  logic                 clear_fault,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 measure_valid,
    output logic                 locked,
    output logic                 fault
);

    localparam int unsigned HIGH_VAL = EXPECTED_HALF + TOLERANCE;
    localparam int unsigned LOW_VAL  = (EXPECTED_HALF > TOLERANCE) ?
                                       (EXPECTED_HALF - TOLERANCE) : 0;
    localparam int unsigned GOOD_W   = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(HIGH_VAL);
    localparam logic [GOOD_W-1:0]    GOOD_LAST   = GOOD_W'(LOCK_COUNT - 1);

    logic                 w_edge_pulse;
    logic [CNT_WIDTH-1:0] w_measured;
    logic                 w_meas_good;
    logic                 w_timeout;
    logic                 w_lock_reached;

    logic [CNT_WIDTH-1:0] r_half_cnt;
    mon_state_t           r_state;
    logic [GOOD_W-1:0]    r_good_cnt;
    logic [CNT_WIDTH-1:0] r_half_period;
    logic                 r_measure_valid;
    logic                 r_locked;
    logic                 r_fault;

    // Input path: synchronize the slow clock and detect both edges
    sync_edge_detect u_sync_edge_detect (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .i_async      (clock_slow_input),
        .o_edge_pulse (w_edge_pulse)
    );

    // Half-period counter: restarts on every edge pulse, saturates at all-ones
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_half_cnt <= '0;
        end else if (w_edge_pulse) begin
            r_half_cnt <= '0;
        end else if (r_half_cnt != CNT_MAX) begin
            r_half_cnt <= r_half_cnt + CNT_WIDTH'(1);
        end
    end

    // Pulses N cycles apart measure N; saturated count stays pinned at max
    assign w_measured     = (r_half_cnt == CNT_MAX) ? CNT_MAX
                                                    : (r_half_cnt + CNT_WIDTH'(1));
    assign w_meas_good    = in_window(32'(w_measured), 32'(LOW_VAL), 32'(HIGH_VAL));
    assign w_timeout      = !w_edge_pulse && (r_half_cnt == TIMEOUT_CNT);
    assign w_lock_reached = (r_good_cnt == GOOD_LAST);

    // Monitor state machine with registered outputs
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_good_cnt      <= '0;
            r_half_period   <= '0;
            r_measure_valid <= 1'b0;
            r_locked        <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_measure_valid <= 1'b0;
            if (!enable) begin
                r_state    <= ST_IDLE;
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
                r_fault    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ACQUIRE;
                    end

                    // First edge only restarts the counter; no capture yet
                    ST_ACQUIRE: begin
                        if (w_edge_pulse) begin
                            r_state <= ST_MEASURE;
                        end
                    end

                    ST_MEASURE: begin
                        if (w_edge_pulse) begin
                            r_half_period   <= w_measured;
                            r_measure_valid <= 1'b1;
                            if (w_meas_good) begin
                                if (w_lock_reached) begin
                                    r_state    <= ST_LOCKED;
                                    r_locked   <= 1'b1;
                                    r_good_cnt <= '0;
                                end else begin
                                    r_good_cnt <= r_good_cnt + GOOD_W'(1);
                                end
                            end else begin
                                r_good_cnt <= '0;
                            end
                        end else if (w_timeout) begin
                            r_good_cnt <= '0;
                            r_state    <= ST_ACQUIRE;
                        end
                    end

                    ST_LOCKED: begin
                        if (w_edge_pulse) begin
                            r_half_period   <= w_measured;
                            r_measure_valid <= 1'b1;
                            if (!w_meas_good) begin
                                r_state  <= ST_FAULT;
                                r_locked <= 1'b0;
                                r_fault  <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_state  <= ST_FAULT;
                            r_locked <= 1'b0;
                            r_fault  <= 1'b1;
                        end
                    end

                    // Sticky until cleared; a coincident edge is discarded
                    ST_FAULT: begin
                        if (clear_fault) begin
                            r_state <= ST_ACQUIRE;
                            r_fault <= 1'b0;
                        end
                    end

                    default: begin
                        r_state    <= ST_IDLE;
                        r_good_cnt <= '0;
                        r_locked   <= 1'b0;
                        r_fault    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign half_period   = r_half_period;
    assign measure_valid = r_measure_valid;
    assign locked        = r_locked;
    assign fault         = r_fault;

endmodule : clk_monitor

// File: tb/tb_clk_monitor.sv
// ----------------------------------------------------------------------------
// tb_clk_monitor
// Directed scenarios followed by randomized half-periods, clear_fault and
// enable activity, compared every cycle against a reference model that works
// on edge timestamps: each slow-clock transition sampled at clk_in edge k is
// handled at edge k+3, a measurement is the distance between handled edges,
// and a timeout is a gap of EXPECTED_HALF+TOLERANCE+1 edges with no handled
// transition.
// ----------------------------------------------------------------------------
module tb_clk_monitor;

    localparam int EXP_HALF   = 50;
    localparam int TOL        = 2;
    localparam int LOCK_N     = 4;
    localparam int CW         = 16;
    localparam int GAP_LIMIT  = EXP_HALF + TOL + 1;

    localparam int MD_OFF   = 0;
    localparam int MD_WAIT  = 1;
    localparam int MD_RUN   = 2;
    localparam int MD_LOCK  = 3;
    localparam int MD_FAULT = 4;

    logic          clk_in;
    logic          reset_n;
    logic          enable;
    logic          clock_slow_input;
    logic          clear_fault;
    logic [CW-1:0] half_period;
    logic          measure_valid;
    logic          locked;
    logic          fault;

    int checks;
    int errors;

    // Reference model state
    int cyc;
    int last_pulse;
    int due_q[$];
    bit prev_slow;
    int m_mode;
    int m_good;
    int exp_hp;
    bit exp_mv;

    // Stimulus state
    bit arm_clear;
    int dis_left;

    clk_monitor #(
        .EXPECTED_HALF (EXP_HALF),
        .TOLERANCE     (TOL),
        .LOCK_COUNT    (LOCK_N),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_in           (clk_in),
        .reset_n          (reset_n),
        .enable           (enable),
        .clock_slow_input (clock_slow_input),
        .clear_fault      (clear_fault),
        .half_period      (half_period),
        .measure_valid    (measure_valid),
        .locked           (locked),
        .fault            (fault)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = MD_OFF;
        m_good     = 0;
        exp_hp     = 0;
        exp_mv     = 1'b0;
        due_q.delete();
        prev_slow  = 1'b0;
        last_pulse = cyc;
    endtask

    task automatic check_outputs();
        chk("measure_valid", 32'(measure_valid), 32'(exp_mv));
        chk("half_period",   32'(half_period),   32'(exp_hp));
        chk("locked",        32'(locked),        32'(m_mode == MD_LOCK));
        chk("fault",         32'(fault),         32'(m_mode == MD_FAULT));
    endtask

    // One clk_in edge: advance the model with the inputs in effect, then check
    task automatic step();
        bit pulse;
        bit tmo;
        int meas;
        @(posedge clk_in);
        cyc++;
        if (!reset_n) begin
            model_reset();
        end else begin
            pulse = (due_q.size() > 0) && (due_q[0] == cyc);
            if (pulse) void'(due_q.pop_front());
            meas   = cyc - last_pulse;
            tmo    = !pulse && (meas == GAP_LIMIT);
            exp_mv = 1'b0;
            if (!enable) begin
                m_mode = MD_OFF;
                m_good = 0;
            end else begin
                case (m_mode)
                    MD_OFF:  m_mode = MD_WAIT;
                    MD_WAIT: if (pulse) m_mode = MD_RUN;
                    MD_RUN: begin
                        if (pulse) begin
                            exp_hp = meas;
                            exp_mv = 1'b1;
                            if (meas >= EXP_HALF - TOL && meas <= EXP_HALF + TOL) begin
                                m_good++;
                                if (m_good == LOCK_N) begin
                                    m_mode = MD_LOCK;
                                    m_good = 0;
                                end
                            end else begin
                                m_good = 0;
                            end
                        end else if (tmo) begin
                            m_good = 0;
                            m_mode = MD_WAIT;
                        end
                    end
                    MD_LOCK: begin
                        if (pulse) begin
                            exp_hp = meas;
                            exp_mv = 1'b1;
                            if (meas < EXP_HALF - TOL || meas > EXP_HALF + TOL)
                                m_mode = MD_FAULT;
                        end else if (tmo) begin
                            m_mode = MD_FAULT;
                        end
                    end
                    default: if (clear_fault) m_mode = MD_WAIT;
                endcase
            end
            if (pulse) last_pulse = cyc;
            if (clock_slow_input != prev_slow) due_q.push_back(cyc + 3);
            prev_slow = clock_slow_input;
        end
        #1;
        check_outputs();
    endtask

    // Run n cycles; optionally randomize clear_fault and enable drop-outs
    task automatic run_cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            clear_fault = 1'b0;
            if (arm_clear && due_q.size() > 0 && due_q[0] == cyc + 1) begin
                clear_fault = 1'b1;
                arm_clear   = 1'b0;
            end else if (rnd) begin
                clear_fault = ($urandom_range(0, 59) == 0);
                if (dis_left > 0) begin
                    dis_left--;
                    if (dis_left == 0) enable = 1'b1;
                end else if ($urandom_range(0, 1999) == 0) begin
                    enable   = 1'b0;
                    dis_left = $urandom_range(1, 40);
                end
            end
            step();
        end
        clear_fault = 1'b0;
    endtask

    task automatic half(input int n, input bit rnd);
        clock_slow_input = ~clock_slow_input;
        run_cycles(n, rnd);
    endtask

    // Asynchronous reset mid-operation: outputs must clear without a clock
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("async_rst_half_period",   32'(half_period),   32'd0);
        chk("async_rst_measure_valid", 32'(measure_valid), 32'd0);
        chk("async_rst_locked",        32'(locked),        32'd0);
        chk("async_rst_fault",         32'(fault),         32'd0);
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    initial begin
        int p;
        int r;
        checks           = 0;
        errors           = 0;
        cyc              = 0;
        arm_clear        = 1'b0;
        dis_left         = 0;
        reset_n          = 1'b0;
        enable           = 1'b0;
        clock_slow_input = 1'b0;
        clear_fault      = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step();
        reset_n = 1'b1;
        run_cycles(2, 1'b0);

        // Nominal 50-cycle half-periods: lock after the 5th transition
        enable = 1'b1;
        repeat (7) half(50, 1'b0);
        chk("s1_locked", 32'(locked), 32'd1);

        // Out of tolerance (53) never locks; 48 is inside tolerance and locks
        enable = 1'b0;
        run_cycles(5, 1'b0);
        enable = 1'b1;
        repeat (6) half(53, 1'b0);
        chk("s2_no_lock_53", 32'(locked), 32'd0);
        chk("s2_hp_53", 32'(half_period), 32'd53);
        repeat (7) half(48, 1'b0);
        chk("s2_lock_48", 32'(locked), 32'd1);
        repeat (8) half($urandom_range(48, 52), 1'b0);

        // Slow clock stops: timeout while locked gives a sticky fault
        run_cycles(120, 1'b0);
        chk("s3_fault", 32'(fault), 32'd1);
        chk("s3_unlocked", 32'(locked), 32'd0);

        // clear_fault coincident with an edge pulse, then relock
        arm_clear = 1'b1;
        repeat (8) half(50, 1'b0);
        chk("s4_relocked", 32'(locked), 32'd1);
        chk("s4_fault_cleared", 32'(fault), 32'd0);

        // Enable dropped while locked, then full reacquisition
        run_cycles(17, 1'b0);
        enable = 1'b0;
        run_cycles(1, 1'b0);
        chk("s5_unlock_on_disable", 32'(locked), 32'd0);
        repeat (3) half(50, 1'b0);
        enable = 1'b1;
        repeat (7) half(50, 1'b0);
        chk("s5_relocked", 32'(locked), 32'd1);

        // Reset in the middle of MEASURE, then behaves like a fresh start
        enable = 1'b0;
        run_cycles(3, 1'b0);
        enable = 1'b1;
        repeat (3) half(50, 1'b0);
        run_cycles(20, 1'b0);
        do_reset();
        repeat (7) half(50, 1'b0);
        chk("s6_locked_after_reset", 32'(locked), 32'd1);

        // Randomized half-periods, holds, clear_fault and enable activity
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)
                p = $urandom_range(EXP_HALF - TOL, EXP_HALF + TOL);
            else if (r < 90)
                p = ($urandom_range(0, 1) == 0) ? $urandom_range(44, 47)
                                                : $urandom_range(53, 56);
            else
                p = $urandom_range(57, 130);
            half(p, 1'b1);
        end
        enable = 1'b1;
        run_cycles(10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_monitor
